// File: rtl/fpu_pkg.sv
// Shared FPU types and widths for single-precision normalisation.
package fpu_pkg;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = MANT_W - 1;
    localparam int unsigned GRS_W  = 3;
    localparam int unsigned LZC_W  = 5;
    localparam int unsigned E_W    = EXP_W + 2;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } norm_dir_t;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic unf;
    } norm_flags_t;

endpackage

// File: rtl/fp_lzc24.sv
// Combinational leading-zero count of a 24-bit significand; an all-zero input returns 24.
module fp_lzc24
    import fpu_pkg::*;
(
    input  logic [MANT_W-1:0] mant,
    output logic [LZC_W-1:0]  count
);

    // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
    always_comb begin
        count = LZC_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (mant[i]) begin
                count = LZC_W'(MANT_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_shifter.sv
// FPU post-add normalisation: two-stage valid/ready pipeline, shift + exponent adjust + flags.
// Optional round-to-nearest-even enabled by defining FP_NORM_ROUND_EN.
module fp_norm_shifter
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_cout,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [GRS_W-1:0]  in_grs,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf
);

    localparam logic signed [E_W-1:0] E_OVF  = 10'sd255;
    localparam logic signed [E_W-1:0] E_ZERO = 10'sd0;
    localparam logic signed [E_W-1:0] E_ONE  = 10'sd1;

    if (MANT_W != 24) begin : g_mant_w_check
        $error("fp_norm_shifter supports MANT_W == 24 only");
    end

    logic              s1_valid;
    norm_dir_t         s1_dir;
    logic [MANT_W-1:0] s1_mant;
    logic [EXP_W-1:0]  s1_exp;
    logic              s1_sign;
    logic              s1_zero;
    logic [LZC_W-1:0]  s1_n;
    logic              s2_valid;
    norm_flags_t       s2_flags;
    logic              s1_ready;
    logic              s2_ready;
    logic [LZC_W-1:0]  lz_count;

`ifdef FP_NORM_ROUND_EN
    logic [GRS_W-1:0]  s1_grs;
`else
    logic              unused_grs;
    assign unused_grs = ^in_grs;
`endif

    assign s2_ready  = ~s2_valid | out_ready;
    assign s1_ready  = ~s1_valid | s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = s2_valid;
    assign out_zero  = s2_flags.zero;
    assign out_ovf   = s2_flags.ovf;
    assign out_unf   = s2_flags.unf;

    fp_lzc24 u_lzc (
        .mant  (in_mant),
        .count (lz_count)
    );

    // Stage 1: capture operands together with shift direction and distance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_dir   <= DIR_L;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_n     <= '0;
`ifdef FP_NORM_ROUND_EN
            s1_grs   <= '0;
`endif
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_dir  <= in_cout ? DIR_R : DIR_L;
                s1_mant <= in_mant;
                s1_exp  <= in_exp;
                s1_sign <= in_sign;
                s1_zero <= ~in_cout & (in_mant == '0);
                s1_n    <= lz_count;
`ifdef FP_NORM_ROUND_EN
                s1_grs  <= in_grs;
`endif
            end
        end
    end

    logic signed [E_W-1:0] e_base;
    logic signed [E_W-1:0] e_norm;
    logic [FRAC_W-1:0]     frac_rn;
    logic [FRAC_W-1:0]     frac_c;
    logic [EXP_W-1:0]      exp_c;
    norm_flags_t           flags_c;
    logic                  unused_hidden;

    assign e_base = $signed({2'b00, s1_exp});

`ifdef FP_NORM_ROUND_EN
    localparam int unsigned W_W   = MANT_W + GRS_W;
    localparam int unsigned SIG_W = MANT_W + 1;
    logic [W_W-1:0]   w_sh;
    logic             round_up;
    logic [SIG_W-1:0] sig_rnd;
`else
    logic [MANT_W-1:0] m_sh;
`endif

    // Stage 2 datapath: shift, exponent adjust and (optionally) RNE rounding.
    always_comb begin
        e_norm        = '0;
        frac_rn       = '0;
        unused_hidden = 1'b0;
`ifdef FP_NORM_ROUND_EN
        w_sh     = '0;
        round_up = 1'b0;
        sig_rnd  = '0;
        if (s1_dir == DIR_R) begin
            // The bit shifted out of the working significand folds into sticky.
            w_sh   = {1'b1, s1_mant, s1_grs[GRS_W-1], |s1_grs[GRS_W-2:0]};
            e_norm = e_base + E_ONE;
        end else begin
            w_sh   = {s1_mant, s1_grs} << s1_n;
            e_norm = e_base - $signed({5'b0, s1_n});
        end
        round_up = w_sh[2] & (w_sh[3] | w_sh[1] | w_sh[0]);
        sig_rnd  = {1'b0, w_sh[W_W-1:GRS_W]} + SIG_W'(round_up);
        if (sig_rnd[MANT_W]) begin
            frac_rn = '0;
            e_norm  = e_norm + E_ONE;
        end else begin
            frac_rn = sig_rnd[FRAC_W-1:0];
        end
        unused_hidden = sig_rnd[FRAC_W];
`else
        m_sh = '0;
        if (s1_dir == DIR_R) begin
            m_sh   = {1'b1, s1_mant[MANT_W-1:1]};
            e_norm = e_base + E_ONE;
        end else begin
            m_sh   = s1_mant << s1_n;
            e_norm = e_base - $signed({5'b0, s1_n});
        end
        frac_rn       = m_sh[FRAC_W-1:0];
        unused_hidden = m_sh[FRAC_W];
`endif
    end

    // Result selection with zero > overflow > underflow > normal priority.
    always_comb begin
        flags_c = '0;
        exp_c   = '0;
        frac_c  = '0;
        if (s1_zero) begin
            flags_c.zero = 1'b1;
        end else if (e_norm >= E_OVF) begin
            flags_c.ovf = 1'b1;
            exp_c       = EXP_MAX;
        end else if (e_norm <= E_ZERO) begin
            flags_c.unf = 1'b1;
        end else begin
            exp_c  = e_norm[EXP_W-1:0];
            frac_c = frac_rn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_frac <= '0;
            s2_flags <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign <= s1_sign;
                out_exp  <= exp_c;
                out_frac <= frac_c;
                s2_flags <= flags_c;
            end
        end
    end

endmodule
